// File: rtl/sprite_pkg.sv
// Shared sprite geometry, animation constants and address-pipeline types.
package sprite_pkg;

    localparam int unsigned SPRITE_W        = 21;
    localparam int unsigned SPRITE_H        = 21;
    localparam int unsigned SPRITE_ADDR_W   = 9;
    localparam int unsigned NUM_WALK_FRAMES = 4;
    localparam int unsigned FRAME_DIV       = 6;
    localparam int unsigned SCREEN_W        = 640;
    localparam int unsigned SCREEN_H        = 480;

    localparam int unsigned COORD_W     = 10;
    localparam int unsigned DELTA_W     = COORD_W + 1;
    localparam int unsigned LOCAL_W     = 5;
    localparam int unsigned FRAME_SEL_W = $clog2(NUM_WALK_FRAMES);

    typedef logic [COORD_W-1:0]       coord_t;
    typedef logic [SPRITE_ADDR_W-1:0] sprite_addr_t;
    typedef logic [DELTA_W-1:0]       delta_t;
    typedef logic [LOCAL_W-1:0]       local_t;

    // Stage-1 payload: box test result plus sprite-local row/column.
    typedef struct packed {
        logic   in_box;
        local_t row;
        local_t col;
    } stage1_t;

    // Row start address; constant multiply, reduces to shifts and adds.
    function automatic sprite_addr_t row_base(input local_t row);
        return sprite_addr_t'(row) * sprite_addr_t'(SPRITE_W);
    endfunction

endpackage

// File: rtl/anim_sequencer.sv
// Walk-animation frame sequencer; advances only on frame_tick so frame_sel is stable per frame.
module anim_sequencer #(
    parameter int unsigned NUM_FRAMES = 4,
    parameter int unsigned FRAME_DIV  = 6
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          frame_tick,
    input  logic                          moving,
    output logic [$clog2(NUM_FRAMES)-1:0] frame_sel
);

    localparam int unsigned SEL_W = $clog2(NUM_FRAMES);
    localparam int unsigned DIV_W = $clog2(FRAME_DIV);

    logic [DIV_W-1:0] div_q, div_d;
    logic [SEL_W-1:0] frame_q, frame_d;

    always_comb begin
        div_d   = div_q;
        frame_d = frame_q;
        if (frame_tick) begin
            if (!moving) begin
                div_d   = '0;
                frame_d = '0;
            end else if (div_q == DIV_W'(FRAME_DIV - 1)) begin
                div_d   = '0;
                frame_d = (frame_q == SEL_W'(NUM_FRAMES - 1)) ? '0 : frame_q + SEL_W'(1);
            end else begin
                div_d   = div_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= '0;
            frame_q <= '0;
        end else begin
            div_q   <= div_d;
            frame_q <= frame_d;
        end
    end

    assign frame_sel = frame_q;

endmodule

// File: rtl/sprite_addr_gen.sv
// Two-stage sprite ROM address pipeline with aligned hit flag, plus walk-animation frame select.
module sprite_addr_gen
    import sprite_pkg::*;
(
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic [COORD_W-1:0]       DrawX,
    input  logic [COORD_W-1:0]       DrawY,
    input  logic                     pixel_valid,
    input  logic [COORD_W-1:0]       SpriteX,
    input  logic [COORD_W-1:0]       SpriteY,
    input  logic                     facing_left,
    input  logic                     moving,
    input  logic                     frame_tick,
    output logic [SPRITE_ADDR_W-1:0] read_address,
    output logic                     hit,
    output logic [FRAME_SEL_W-1:0]   frame_sel
);

    delta_t       dx, dy;
    stage1_t      s1_d, s1_q;
    sprite_addr_t addr_d, addr_q;
    logic         hit_d, hit_q;

    // 11-bit differences keep sprites hanging past column 1023 from aliasing.
    always_comb begin
        dx = delta_t'(DrawX) - delta_t'(SpriteX);
        dy = delta_t'(DrawY) - delta_t'(SpriteY);

        s1_d.in_box = pixel_valid
                    & ~dx[DELTA_W-1] & (dx < delta_t'(SPRITE_W))
                    & ~dy[DELTA_W-1] & (dy < delta_t'(SPRITE_H));
        s1_d.row    = local_t'(dy);
        s1_d.col    = facing_left ? (local_t'(SPRITE_W - 1) - local_t'(dx)) : local_t'(dx);
    end

    always_comb begin
        hit_d  = s1_q.in_box;
        addr_d = '0;
        if (s1_q.in_box) begin
            addr_d = row_base(s1_q.row) + sprite_addr_t'(s1_q.col);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_q   <= '0;
            addr_q <= '0;
            hit_q  <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            addr_q <= addr_d;
            hit_q  <= hit_d;
        end
    end

    assign read_address = addr_q;
    assign hit          = hit_q;

    anim_sequencer #(
        .NUM_FRAMES (NUM_WALK_FRAMES),
        .FRAME_DIV  (FRAME_DIV)
    ) u_anim (
        .clk        (Clk),
        .rst_n      (Reset_n),
        .frame_tick (frame_tick),
        .moving     (moving),
        .frame_sel  (frame_sel)
    );

endmodule

// File: tb/tb_sprite_addr_gen.sv
// Scoreboard bench for sprite_addr_gen: directed pixels, mirroring, clipping, sweep and animation.
module tb_sprite_addr_gen;
    import sprite_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic [9:0] DrawX = '0, DrawY = '0, SpriteX = '0, SpriteY = '0;
    logic       pixel_valid = 1'b0, facing_left = 1'b0, moving = 1'b0, frame_tick = 1'b0;
    logic [8:0] read_address;
    logic       hit;
    logic [1:0] frame_sel;

    always #5 Clk = ~Clk;

    sprite_addr_gen dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .pixel_valid  (pixel_valid),
        .SpriteX      (SpriteX),
        .SpriteY      (SpriteY),
        .facing_left  (facing_left),
        .moving       (moving),
        .frame_tick   (frame_tick),
        .read_address (read_address),
        .hit          (hit),
        .frame_sel    (frame_sel)
    );

    typedef struct {
        logic       hit;
        logic [8:0] addr;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   hits_seen = 0;

    // Tracks which cycles carry a scored pixel, delayed by the 2-clock latency.
    logic drv_v = 1'b0, v1 = 1'b0, v2 = 1'b0;
    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            v1 <= drv_v;
            v2 <= v1;
        end
    end

    always @(negedge Clk) begin
        exp_t e;
        if (v2) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_underflow: output hit=%0b addr=%0d with no expected entry", hit, read_address);
            end else begin
                e = sb.pop_front();
                if (hit !== e.hit || read_address !== e.addr) begin
                    n_err++;
                    $display("FAIL %s: got hit=%0b addr=%0d, expected hit=%0b addr=%0d",
                             e.name, hit, read_address, e.hit, e.addr);
                end
            end
            if (hit === 1'b1) hits_seen++;
        end
    end

    task automatic pix(input int x, input int y, input int sx, input int sy,
                       input logic fl, input logic pv, input logic eh, input int ea,
                       input string nm);
        @(posedge Clk);
        #1;
        DrawX       = 10'(x);
        DrawY       = 10'(y);
        SpriteX     = 10'(sx);
        SpriteY     = 10'(sy);
        facing_left = fl;
        pixel_valid = pv;
        drv_v       = 1'b1;
        sb.push_back('{hit: eh, addr: 9'(ea), name: nm});
    endtask

    task automatic drain();
        @(posedge Clk);
        #1;
        drv_v       = 1'b0;
        pixel_valid = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input logic mv);
        @(posedge Clk);
        #1;
        moving     = mv;
        frame_tick = 1'b1;
        @(posedge Clk);
        #1;
        frame_tick = 1'b0;
        @(posedge Clk);
        #1;
    endtask

    task automatic ticks(input int n, input logic mv);
        for (int i = 0; i < n; i++) tick(mv);
    endtask

    initial begin
        // Reset state, observed before any clock edge
        #3;
        check("rst_hit", int'(hit), 0);
        check("rst_addr", int'(read_address), 0);
        check("rst_frame_sel", int'(frame_sel), 0);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Corners, facing right
        pix(100, 200, 100, 200, 1'b0, 1'b1, 1'b1, 0,   "corner_tl");
        pix(120, 200, 100, 200, 1'b0, 1'b1, 1'b1, 20,  "corner_tr");
        pix(100, 220, 100, 200, 1'b0, 1'b1, 1'b1, 420, "corner_bl");
        pix(120, 220, 100, 200, 1'b0, 1'b1, 1'b1, 440, "corner_br");
        pix(121, 200, 100, 200, 1'b0, 1'b1, 1'b0, 0,   "right_of_box");
        pix(99,  200, 100, 200, 1'b0, 1'b1, 1'b0, 0,   "left_of_box");
        pix(100, 221, 100, 200, 1'b0, 1'b1, 1'b0, 0,   "below_box");
        pix(100, 199, 100, 200, 1'b0, 1'b1, 1'b0, 0,   "above_box");

        // Mirrored
        pix(100, 200, 100, 200, 1'b1, 1'b1, 1'b1, 20,  "mirror_tl");
        pix(120, 205, 100, 200, 1'b1, 1'b1, 1'b1, 105, "mirror_r5");
        pix(110, 210, 100, 200, 1'b1, 1'b1, 1'b1, 220, "mirror_centre");

        // Screen-edge clipping, invalid pixels, no 10-bit aliasing
        pix(639, 479, 630, 470, 1'b0, 1'b1, 1'b1, 198, "clip_br");
        pix(0,   479, 630, 470, 1'b0, 1'b1, 1'b0, 0,   "clip_nowrap");
        pix(635, 475, 630, 470, 1'b0, 1'b0, 1'b0, 0,   "pv_low");
        pix(5,   200, 1020, 200, 1'b0, 1'b1, 1'b0, 0,  "no_alias");
        drain();

        // Full-row sweep at one pixel per clock
        hits_seen = 0;
        for (int x = 0; x < SCREEN_W; x++) begin
            if (x >= 100 && x <= 120)
                pix(x, 205, 100, 200, 1'b0, 1'b1, 1'b1, 105 + (x - 100), "sweep_in");
            else
                pix(x, 205, 100, 200, 1'b0, 1'b1, 1'b0, 0, "sweep_out");
        end
        drain();
        check("sweep_hit_count", hits_seen, 21);

        // Animation sequencer
        ticks(5, 1'b1);
        check("anim_5_ticks", int'(frame_sel), 0);
        tick(1'b1);
        check("anim_6_ticks", int'(frame_sel), 1);
        for (int i = 0; i < 4; i++) begin
            @(posedge Clk);
            #1;
            moving = ~moving;
        end
        check("anim_hold_no_tick", int'(frame_sel), 1);
        ticks(18, 1'b1);
        check("anim_24_wrap", int'(frame_sel), 0);
        ticks(18, 1'b1);
        check("anim_frame3", int'(frame_sel), 3);
        tick(1'b0);
        check("anim_stop_clear", int'(frame_sel), 0);
        ticks(5, 1'b1);
        check("anim_restart_5", int'(frame_sel), 0);
        tick(1'b1);
        check("anim_restart_6", int'(frame_sel), 1);
        ticks(6, 1'b1);
        check("anim_frame2", int'(frame_sel), 2);

        // Asynchronous reset mid-frame with the sprite on screen
        @(posedge Clk);
        #1;
        DrawX = 10'd110; DrawY = 10'd210; SpriteX = 10'd100; SpriteY = 10'd200;
        facing_left = 1'b0; pixel_valid = 1'b1; moving = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check("pre_reset_hit", int'(hit), 1);
        check("pre_reset_addr", int'(read_address), 220);
        #2;
        Reset_n = 1'b0;
        #1;
        check("async_rst_hit", int'(hit), 0);
        check("async_rst_addr", int'(read_address), 0);
        check("async_rst_frame_sel", int'(frame_sel), 0);
        @(negedge Clk);
        pixel_valid = 1'b0;
        Reset_n = 1'b1;

        repeat (10) begin
            if (sb.size() != 0) @(posedge Clk);
        end
        check("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
